// File: rtl/reset_seq_pkg.sv
// Shared types, defaults and sizing helpers for the reset sequencer.
// Imported by the lock filter and the sequencer top level.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStretch  = 2'd1,
        StRelease  = 2'd2,
        StRun      = 2'd3
    } seq_state_e;

    localparam int unsigned DefNumCh         = 4;
    localparam int unsigned DefSyncStages    = 2;
    localparam int unsigned DefLockFilter    = 8;
    localparam int unsigned DefStretchCycles = 32;
    localparam int unsigned DefStaggerCycles = 16;
    localparam int unsigned DefLossCntW      = 8;

    // Bits needed to hold 0..max_cnt; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        int unsigned w;
        w = (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
        return w;
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Synchronises the asynchronous PLL lock flag and only trusts it after
// LOCK_FILTER consecutive high samples.
module lock_filter
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned LOCK_FILTER = DefLockFilter
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int unsigned CntW = cnt_width(LOCK_FILTER);
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_FILTER);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   lock_sync;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked};
        lock_sync = sync_q[SYNC_STAGES-1];
        cnt_d     = cnt_q;
        if (!lock_sync) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_ok = (cnt_q == CntMax);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: waits for a trusted PLL lock, stretches reset,
// then releases channels one by one; lock loss or a software request restarts it.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = DefNumCh,
    parameter int unsigned SYNC_STAGES    = DefSyncStages,
    parameter int unsigned LOCK_FILTER    = DefLockFilter,
    parameter int unsigned STRETCH_CYCLES = DefStretchCycles,
    parameter int unsigned STAGGER_CYCLES = DefStaggerCycles,
    parameter int unsigned LOSS_CNT_W     = DefLossCntW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic [NUM_CH-1:0]     rst_out,
    output logic                  all_released,
    output logic                  seq_busy,
    output logic                  lock_loss_sticky,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int unsigned StrW = cnt_width(STRETCH_CYCLES);
    localparam int unsigned StgW = cnt_width(STAGGER_CYCLES);
    localparam int unsigned ChW  = cnt_width(NUM_CH - 1);

    localparam logic [StrW-1:0] StretchLast = StrW'(STRETCH_CYCLES - 1);
    localparam logic [StgW-1:0] StaggerLast =
        StgW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [ChW-1:0]  LastCh      = ChW'(NUM_CH - 1);

    logic lock_ok;

    lock_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    seq_state_e            state_q, state_d;
    logic [StrW-1:0]       str_cnt_q, str_cnt_d;
    logic [StgW-1:0]       stg_cnt_q, stg_cnt_d;
    logic [ChW-1:0]        ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0]     rst_out_q, rst_out_d;
    logic                  all_rel_q, all_rel_d;
    logic                  busy_q, busy_d;
    logic                  sticky_q, sticky_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        state_d    = state_q;
        str_cnt_d  = str_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        ch_idx_d   = ch_idx_q;
        rst_out_d  = rst_out_q;
        sticky_d   = sticky_q;
        loss_cnt_d = loss_cnt_q;

        if (state_q == StWaitLock) begin
            rst_out_d = '1;
            str_cnt_d = '0;
            if (lock_ok) begin
                state_d = StStretch;
            end
        end else if (!lock_ok) begin
            // Lock loss outranks a simultaneous software request.
            state_d   = StWaitLock;
            rst_out_d = '1;
            str_cnt_d = '0;
            sticky_d  = 1'b1;
            if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
            end
        end else if (sw_rst_req) begin
            state_d   = StStretch;
            rst_out_d = '1;
            str_cnt_d = '0;
        end else begin
            unique case (state_q)
                StStretch: begin
                    if (str_cnt_q == StretchLast) begin
                        str_cnt_d = '0;
                        stg_cnt_d = '0;
                        if (STAGGER_CYCLES == 0 || NUM_CH == 1) begin
                            rst_out_d = '0;
                            state_d   = StRun;
                        end else begin
                            rst_out_d    = rst_out_q;
                            rst_out_d[0] = 1'b0;
                            ch_idx_d     = ChW'(1);
                            state_d      = StRelease;
                        end
                    end else begin
                        str_cnt_d = str_cnt_q + StrW'(1);
                    end
                end
                StRelease: begin
                    if (stg_cnt_q == StaggerLast) begin
                        stg_cnt_d = '0;
                        rst_out_d = rst_out_q & ~(NUM_CH'(1) << ch_idx_q);
                        if (ch_idx_q == LastCh) begin
                            state_d = StRun;
                        end else begin
                            ch_idx_d = ch_idx_q + ChW'(1);
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + StgW'(1);
                    end
                end
                default: begin
                    rst_out_d = '0;
                end
            endcase
        end

        // Status flags are computed from next state so they flip with rst_out.
        all_rel_d = (rst_out_d == '0);
        busy_d    = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWaitLock;
            str_cnt_q  <= '0;
            stg_cnt_q  <= '0;
            ch_idx_q   <= '0;
            rst_out_q  <= '1;
            all_rel_q  <= 1'b0;
            busy_q     <= 1'b1;
            sticky_q   <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            str_cnt_q  <= str_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            ch_idx_q   <= ch_idx_d;
            rst_out_q  <= rst_out_d;
            all_rel_q  <= all_rel_d;
            busy_q     <= busy_d;
            sticky_q   <= sticky_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign rst_out          = rst_out_q;
    assign all_released     = all_rel_q;
    assign seq_busy         = busy_q;
    assign lock_loss_sticky = sticky_q;
    assign lock_loss_count  = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a small fast instance
// (3 channels, zero stagger, 2-bit loss counter) for saturation checks.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pll, sw;
    logic [3:0] rst_out;
    logic       all_rel, busy, sticky;
    logic [7:0] cnt;

    logic       rst_b, pll_b, sw_b;
    logic [2:0] rst_out_b;
    logic       all_rel_b, busy_b, sticky_b;
    logic [1:0] cnt_b;

    reset_sequencer #(
        .NUM_CH(4), .SYNC_STAGES(2), .LOCK_FILTER(8),
        .STRETCH_CYCLES(32), .STAGGER_CYCLES(16), .LOSS_CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll), .sw_rst_req(sw),
        .rst_out(rst_out), .all_released(all_rel), .seq_busy(busy),
        .lock_loss_sticky(sticky), .lock_loss_count(cnt)
    );

    reset_sequencer #(
        .NUM_CH(3), .SYNC_STAGES(2), .LOCK_FILTER(2),
        .STRETCH_CYCLES(4), .STAGGER_CYCLES(0), .LOSS_CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pll_locked(pll_b), .sw_rst_req(sw_b),
        .rst_out(rst_out_b), .all_released(all_rel_b), .seq_busy(busy_b),
        .lock_loss_sticky(sticky_b), .lock_loss_count(cnt_b)
    );

    typedef struct {
        int         due;
        bit         unit_b;
        logic [3:0] r;
        logic       a;
        logic       b;
        logic       s;
        logic [7:0] c;
        string      tag;
    } exp_t;

    typedef struct {
        int         off;
        logic [3:0] r;
        logic       a;
        logic       b;
    } pv_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;

    task automatic push(input int due, input bit ub, input logic [3:0] r, input logic a,
                        input logic b, input logic s, input logic [7:0] c, input string tag);
        exp_t e;
        int   i;
        e.due = due; e.unit_b = ub; e.r = r; e.a = a; e.b = b; e.s = s; e.c = c;
        e.tag = tag;
        i = 0;
        while (i < sbq.size() && sbq[i].due <= due) i++;
        sbq.insert(i, e);
    endtask

    task automatic check(input exp_t e);
        logic [3:0] ar;
        logic       aa, ab, as;
        logic [7:0] ac;
        if (e.unit_b) begin
            ar = {1'b0, rst_out_b}; aa = all_rel_b; ab = busy_b; as = sticky_b;
            ac = {6'd0, cnt_b};
        end else begin
            ar = rst_out; aa = all_rel; ab = busy; as = sticky; ac = cnt;
        end
        total++;
        if (e.due != edge_cnt || {ar, aa, ab, as, ac} !== {e.r, e.a, e.b, e.s, e.c}) begin
            bad++;
            $display("FAIL %s edge %0d (due %0d): got rst_out=%h all=%b busy=%b sticky=%b cnt=%0d, want rst_out=%h all=%b busy=%b sticky=%b cnt=%0d",
                     e.tag, edge_cnt, e.due, ar, aa, ab, as, ac, e.r, e.a, e.b, e.s, e.c);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        edge_cnt++;
        while (sbq.size() > 0 && sbq[0].due <= edge_cnt) begin
            e = sbq.pop_front();
            check(e);
        end
    endtask

    task automatic run_to(input int e);
        while (edge_cnt < e) tick();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sbq.size() > 0 && guard < 2000) begin
            tick();
            guard++;
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pv_t pu_tab [8];
        int  t0, t1, l, s, s2;

        pu_tab[0] = '{41, 4'hF, 1'b0, 1'b1};
        pu_tab[1] = '{42, 4'hE, 1'b0, 1'b1};
        pu_tab[2] = '{57, 4'hE, 1'b0, 1'b1};
        pu_tab[3] = '{58, 4'hC, 1'b0, 1'b1};
        pu_tab[4] = '{73, 4'hC, 1'b0, 1'b1};
        pu_tab[5] = '{74, 4'h8, 1'b0, 1'b1};
        pu_tab[6] = '{89, 4'h8, 1'b0, 1'b1};
        pu_tab[7] = '{90, 4'h0, 1'b1, 1'b0};

        rst = 1'b1; pll = 1'b0; sw = 1'b0;
        rst_b = 1'b1; pll_b = 1'b0; sw_b = 1'b0;

        for (int i = 0; i < 5; i++) begin
            push(edge_cnt + 1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "reset");
            push(edge_cnt + 1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 8'd0, "reset_b");
            tick();
        end

        // Power-up with defaults
        rst = 1'b0;
        pll = 1'b1;
        t0 = edge_cnt + 1;
        for (int i = 0; i < 8; i++) begin
            push(t0 + pu_tab[i].off, 1'b0, pu_tab[i].r, pu_tab[i].a, pu_tab[i].b,
                 1'b0, 8'd0, "powerup");
        end
        drain();

        // Reset from RUN, then glitchy lock
        rst = 1'b1; pll = 1'b0;
        push(edge_cnt + 1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "rst_from_run");
        tick();
        rst = 1'b0; pll = 1'b1;
        repeat (5) tick();
        pll = 1'b0;
        tick();
        pll = 1'b1;
        t0 = edge_cnt + 1;
        push(t0 + 20, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "glitch_hold");
        push(t0 + 41, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "glitch_41");
        push(t0 + 42, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 8'd0, "glitch_42");
        push(t0 + 90, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, "glitch_run");
        drain();

        // Lock loss in RUN
        pll = 1'b0;
        l = edge_cnt + 1;
        t1 = l + 1;
        push(l + 2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, "loss_pre");
        push(l + 3, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "loss_resp");
        push(t1 + 41, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "relock_41");
        push(t1 + 42, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 8'd1, "relock_42");
        push(t1 + 90, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd1, "relock_run");
        tick();
        pll = 1'b1;
        drain();

        // Software reset in RUN
        sw = 1'b1;
        s = edge_cnt + 1;
        push(s, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "sw_resp");
        push(s + 31, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "sw_31");
        push(s + 32, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 8'd1, "sw_32");
        push(s + 79, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 8'd1, "sw_79");
        push(s + 80, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd1, "sw_80");
        tick();
        sw = 1'b0;
        drain();

        // Software reset after channel 1 released
        sw = 1'b1;
        s = edge_cnt + 1;
        s2 = s + 50;
        push(s + 48, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 8'd1, "mid_ch1");
        push(s2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "mid_sw_resp");
        push(s2 + 31, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd1, "mid_31");
        push(s2 + 32, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 8'd1, "mid_32");
        push(s2 + 48, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 8'd1, "mid_48");
        push(s2 + 80, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd1, "mid_80");
        tick();
        sw = 1'b0;
        run_to(s2 - 1);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        drain();

        // Lock loss coinciding with a software request, then rst mid-RELEASE
        pll = 1'b0;
        l = edge_cnt + 1;
        push(l + 2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd1, "both_pre");
        push(l + 3, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd2, "both_resp");
        push(l + 4, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd2, "both_once");
        push(l + 35, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd2, "both_no_sw");
        push(l + 42, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 8'd2, "both_41");
        push(l + 43, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 8'd2, "both_42");
        push(l + 49, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 8'd2, "pre_rst");
        push(l + 50, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "rst_mid_rel");
        push(l + 51, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0, "rst_held");
        tick();
        pll = 1'b1;
        tick();
        tick();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        run_to(l + 49);
        rst = 1'b1;
        drain();
        rst = 1'b0;

        // Fast instance: zero stagger and saturating 2-bit loss counter
        rst_b = 1'b0;
        pll_b = 1'b1;
        t0 = edge_cnt + 1;
        push(t0 + 7, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 8'd0, "b_pre");
        push(t0 + 8, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, "b_release");
        drain();
        for (int i = 1; i <= 5; i++) begin
            pll_b = 1'b0;
            l = edge_cnt + 1;
            push(l + 2, 1'b1, 4'h0, 1'b1, 1'b0, (i > 1) ? 1'b1 : 1'b0,
                 8'((i - 1 > 3) ? 3 : i - 1), "b_loss_pre");
            push(l + 3, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 8'((i > 3) ? 3 : i), "b_loss");
            push(l + 9, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 8'((i > 3) ? 3 : i), "b_relock");
            tick();
            pll_b = 1'b1;
            drain();
        end
        rst_b = 1'b1;
        push(edge_cnt + 1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 8'd0, "b_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised multi-channel power-on and lock-loss reset sequencer in the fabric clock domain.
- Synchronises and debounces the clk_wiz `pll_locked` signal.
- Stretches reset, then releases NUM_CH active-high resets one after another at a fixed stagger.
- On lock loss, re-asserts all channels and records the event.
- A software reset request re-runs the stretch and release sequence without waiting for lock.

Parameters:
- NUM_CH, 4: number of reset outputs; must be >= 1.
- SYNC_STAGES, 2: synchroniser flops on `pll_locked`; must be >= 2.
- LOCK_FILTER, 8: consecutive synchronised-high cycles required before lock is trusted; must be >= 1.
- STRETCH_CYCLES, 32: hold time after trusted lock before channel 0 releases; must be >= 1.
- STAGGER_CYCLES, 16: gap between releases of adjacent channels; 0 means all channels release together.
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- clk, input, 1: fabric clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: clk_wiz locked; asynchronous to clk.
- sw_rst_req, input, 1: single-cycle software reset request.
- rst_out, output, NUM_CH: per-channel active-high resets; bit 0 releases first.
- all_released, output, 1: high while every rst_out bit is 0.
- seq_busy, output, 1: high in any state other than RUN.
- lock_loss_sticky, output, 1: set on lock loss; cleared only by rst.
- lock_loss_count, output, LOSS_CNT_W: lock-loss events, saturating.

Behaviour:
- Reset values (rst=1, and all state while held):
  - rst_out = all ones; all_released = 0; seq_busy = 1; lock_loss_sticky = 0; lock_loss_count = 0.
  - Synchroniser flops = 0; filter counter = 0; FSM = WAIT_LOCK.
  - No output glitches low while rst is held.
- All outputs are registered.
- Lock filter:
  - lock_sync = pll_locked delayed through SYNC_STAGES flops.
  - Filter counter clears when lock_sync = 0; otherwise increments, saturating at LOCK_FILTER.
  - lock_ok = (counter == LOCK_FILTER).
  - Any single low sample drops lock_ok on the next cycle.
- FSM states: WAIT_LOCK, STRETCH, RELEASE, RUN.
- WAIT_LOCK:
  - All rst_out = 1.
  - Go to STRETCH when lock_ok = 1.
  - sw_rst_req is ignored.
- STRETCH:
  - All rst_out = 1; counts STRETCH_CYCLES cycles, then enters RELEASE with channel index 0.
- RELEASE:
  - rst_out[k] clears at a fixed offset; once cleared, a channel stays cleared until re-assertion.
  - After the last channel clears, go to RUN.
- RUN:
  - rst_out = 0; all_released = 1; seq_busy = 0.
- Exact release timing:
  - Let cycle 0 be the first rising edge at which pll_locked is sampled high and then stays high.
  - Let D0 = SYNC_STAGES + LOCK_FILTER + STRETCH_CYCLES.
  - rst_out[k] is first observed 0 in cycle D0 + k*STAGGER_CYCLES.
  - all_released rises in the same cycle as the last channel clears.
- Lock loss:
  - Trigger: lock_ok falls while in STRETCH, RELEASE or RUN.
  - Response on the next cycle: all rst_out = 1, all_released = 0, lock_loss_sticky = 1.
  - lock_loss_count increments, saturating at 2^LOSS_CNT_W - 1; FSM returns to WAIT_LOCK.
  - Lock-ok dropping while already in WAIT_LOCK is not counted.
- Software reset:
  - Trigger: sw_rst_req = 1 in STRETCH, RELEASE or RUN.
  - Response on the next cycle: all rst_out = 1; FSM enters STRETCH with the counter restarted.
  - The lock filter is not restarted, so release occurs STRETCH_CYCLES + k*STAGGER_CYCLES cycles after the request cycle.
- Simultaneous lock loss and sw_rst_req: lock loss wins (counted; go to WAIT_LOCK).
- STAGGER_CYCLES = 0: all channels clear in the same cycle D0.
- Internal counter widths: $clog2(max+1) of each respective limit; no wrap-around possible.

Decomposition:
- Package reset_seq_pkg:
  - FSM state enum (WAIT_LOCK, STRETCH, RELEASE, RUN).
  - Default parameter constants.
  - A function returning the counter width for a given maximum count.
- Sub-module lock_filter:
  - Parameters SYNC_STAGES and LOCK_FILTER; ports clk, rst, pll_locked in; lock_ok out.
  - Contains the synchroniser and debounce counter.
- Top level keeps the FSM, stretch/stagger counters, channel mask and loss bookkeeping.

Test Plan:
- Power-up, defaults: hold rst 5 cycles, then raise pll_locked -> rst_out[0..3] clear at cycles 42/58/74/90; all_released rises at 90; seq_busy falls at 90; count = 0.
- Glitch rejection: pll_locked high 5 cycles, low 1 cycle, then high permanently -> no release before cycle 42 measured from the final rise; lock_loss_count = 0; sticky = 0.
- Lock loss in RUN: drop pll_locked for 1 cycle -> after 2 sync cycles + 1, rst_out = 4'hF, sticky = 1, count = 1; re-release follows full D0 timing from the next stable high.
- Software reset in RUN: pulse sw_rst_req at cycle T -> rst_out = 4'hF at T+1; rst_out[0] clears at T+32, rst_out[3] at T+80; count unchanged.
- Mid-release events:
  - sw_rst_req after rst_out[1] cleared -> all re-asserted next cycle; full stagger restarts.
  - Lock loss together with sw_rst_req -> WAIT_LOCK entered and count incremented once.
- Saturation and reset: LOSS_CNT_W = 2, force 5 losses -> count holds at 3; assert rst mid-RELEASE -> all outputs return to reset values on the next edge.
